// File: rtl/peripheral_bus_master.sv
// ============================================================================
// peripheral_bus_master: valid/ready initiator for peripheral regs and memory
// Revision: 1.0
// ============================================================================
`default_nettype none

module peripheral_bus_master #(
   parameter int REGS           = 3,
   parameter int MEM_DEPTH      = 256,
   parameter int MEM_AW         = $clog2(MEM_DEPTH),
   parameter int MEM_RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [MEM_AW:0]     req_addr,
   input  logic [31:0]         req_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   output logic                rsp_error,
   output logic [REGS-1:0]     reg_write_en,
   output logic [31:0]         reg_data_in,
   input  logic [REGS*32-1:0]  reg_data_out,
   output logic                mem_write_en,
   output logic [MEM_AW-1:0]   mem_address,
   output logic [31:0]         mem_data_in,
   input  logic [31:0]         mem_data_out
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      MEM_WAIT = 2'd2,
      RESP     = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_write;
   logic [MEM_AW:0]     r_addr;
   logic [2:0]          r_wait_cnt;

   logic                w_accept;
   logic                w_reg_hit;
   logic [31:0]         w_reg_rd;
   logic                w_write_next;
   logic [MEM_AW:0]     w_addr_next;
   logic [2:0]          w_wait_cnt_next;
   logic                w_req_ready_next;
   logic                w_rsp_valid_next;
   logic [31:0]         w_rsp_rdata_next;
   logic                w_rsp_error_next;
   logic [REGS-1:0]     w_reg_write_en_next;
   logic                w_mem_write_en_next;
   logic [MEM_AW-1:0]   w_mem_address_next;
   logic [31:0]         w_wdata_next;

   assign w_accept = (r_state == IDLE) && req_ready && req_valid;

   // Register index decode of the captured address; out-of-range indices miss.
   always_comb begin
      w_reg_hit = 1'b0;
      w_reg_rd  = '0;
      for (int i = 0; i < REGS; i++) begin
         if (r_addr[MEM_AW-1:0] == MEM_AW'(i)) begin
            w_reg_hit = 1'b1;
            w_reg_rd  = reg_data_out[i*32 +: 32];
         end
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_write_next        = r_write;
      w_addr_next         = r_addr;
      w_wait_cnt_next     = r_wait_cnt;
      w_rsp_valid_next    = rsp_valid;
      w_rsp_rdata_next    = rsp_rdata;
      w_rsp_error_next    = rsp_error;
      w_reg_write_en_next = '0;
      w_mem_write_en_next = 1'b0;
      w_mem_address_next  = mem_address;
      w_wdata_next        = reg_data_in;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_write_next       = req_write;
               w_addr_next        = req_addr;
               w_wdata_next       = req_wdata;
               w_mem_address_next = req_addr[MEM_AW-1:0];
               w_rsp_rdata_next   = '0;
               w_rsp_error_next   = 1'b0;
               w_state_next       = ACCESS;
               // Strobes are registered here so they are high during ACCESS only.
               if (req_write) begin
                  if (req_addr[MEM_AW]) begin
                     w_mem_write_en_next = 1'b1;
                  end else begin
                     for (int i = 0; i < REGS; i++) begin
                        w_reg_write_en_next[i] = (req_addr[MEM_AW-1:0] == MEM_AW'(i));
                     end
                  end
               end
            end
         end
         ACCESS: begin
            if (r_addr[MEM_AW] && !r_write) begin
               w_wait_cnt_next = '0;
               w_state_next    = MEM_WAIT;
            end else begin
               if (!r_addr[MEM_AW]) begin
                  if (!w_reg_hit) begin
                     w_rsp_error_next = 1'b1;
                  end else if (!r_write) begin
                     w_rsp_rdata_next = w_reg_rd;
                  end
               end
               w_rsp_valid_next = 1'b1;
               w_state_next     = RESP;
            end
         end
         MEM_WAIT: begin
            if (r_wait_cnt == 3'(MEM_RD_LATENCY - 1)) begin
               w_rsp_rdata_next = mem_data_out;
               w_rsp_valid_next = 1'b1;
               w_state_next     = RESP;
            end else begin
               w_wait_cnt_next = r_wait_cnt + 3'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_next = 1'b0;
               w_state_next     = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase

      w_req_ready_next = (w_state_next == IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wait_cnt   <= '0;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_error    <= 1'b0;
         reg_write_en <= '0;
         reg_data_in  <= '0;
         mem_write_en <= 1'b0;
         mem_address  <= '0;
         mem_data_in  <= '0;
      end else begin
         r_state      <= w_state_next;
         r_write      <= w_write_next;
         r_addr       <= w_addr_next;
         r_wait_cnt   <= w_wait_cnt_next;
         req_ready    <= w_req_ready_next;
         rsp_valid    <= w_rsp_valid_next;
         rsp_rdata    <= w_rsp_rdata_next;
         rsp_error    <= w_rsp_error_next;
         reg_write_en <= w_reg_write_en_next;
         reg_data_in  <= w_wdata_next;
         mem_write_en <= w_mem_write_en_next;
         mem_address  <= w_mem_address_next;
         mem_data_in  <= w_wdata_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_peripheral_bus_master.sv
// ============================================================================
// tb_peripheral_bus_master: directed self-checking bench for peripheral_bus_master
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_peripheral_bus_master;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_write = 1'b0;
   logic [8:0]   req_addr = '0;
   logic [31:0]  req_wdata = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [31:0]  rsp_rdata;
   logic         rsp_error;
   logic [2:0]   reg_write_en;
   logic [31:0]  reg_data_in;
   logic [95:0]  reg_data_out = {32'hA5A5_0002, 32'h1111_1111, 32'hDEAD_BEEF};
   logic         mem_write_en;
   logic [7:0]   mem_address;
   logic [31:0]  mem_data_in;
   logic [31:0]  mem_data_out;

   logic [31:0]  mem [256];
   int           total = 0;
   int           bad = 0;
   int           reg_we_cnt = 0;
   int           mem_we_cnt = 0;
   int           excl_viol = 0;

   peripheral_bus_master #(
      .REGS(3), .MEM_DEPTH(256), .MEM_AW(8), .MEM_RD_LATENCY(1)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .reg_write_en(reg_write_en), .reg_data_in(reg_data_in), .reg_data_out(reg_data_out),
      .mem_write_en(mem_write_en), .mem_address(mem_address),
      .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   // Synchronous RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_address] <= mem_data_in;
      mem_data_out <= mem[mem_address];
   end

   always @(negedge clk) begin
      if (reg_write_en != 3'b000) reg_we_cnt++;
      if (mem_write_en) mem_we_cnt++;
      if ($countones(reg_write_en) > 1 || (reg_write_en != 3'b000 && mem_write_en)) excl_viol++;
   end

   // Presents a request at a negedge and returns at the first negedge after the accept edge.
   task automatic send(input logic w, input logic [8:0] a, input logic [31:0] d, output bit to);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      to = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (req_ready) begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic take;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      total++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp: got v=%b e=%b d=%h want 0/0/0", rsp_valid, rsp_error, rsp_rdata); end
      total++; if (reg_write_en !== 3'b000 || mem_write_en !== 1'b0) begin bad++; $display("FAIL reset_strobes: got reg=%b mem=%b want 000/0", reg_write_en, mem_write_en); end
      total++; if (mem_address !== 8'h0 || reg_data_in !== 32'h0 || mem_data_in !== 32'h0) begin bad++; $display("FAIL reset_data: got a=%h r=%h m=%h want 0", mem_address, reg_data_in, mem_data_in); end
      reset = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_reg_write;
      bit to; int lat; int r0, m0;
      r0 = reg_we_cnt; m0 = mem_we_cnt;
      send(1'b1, 9'h001, 32'h5, to);
      total++; if (to) begin bad++; $display("FAIL regw_accept: got timeout want accept"); end
      total++; if (reg_write_en !== 3'b010 || reg_data_in !== 32'h5) begin bad++; $display("FAIL regw_strobe: got en=%b d=%h want 010/00000005", reg_write_en, reg_data_in); end
      wait_rsp(lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL regw_latency: got %0d want 2", lat); end
      total++; if (rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL regw_rsp: got e=%b d=%h want 0/0", rsp_error, rsp_rdata); end
      take();
      total++; if (reg_we_cnt - r0 !== 1 || mem_we_cnt - m0 !== 0) begin bad++; $display("FAIL regw_pulses: got reg=%0d mem=%0d want 1/0", reg_we_cnt - r0, mem_we_cnt - m0); end
   endtask

   task automatic test_reg_read;
      bit to; int lat;
      send(1'b0, 9'h000, 32'h0, to);
      wait_rsp(lat);
      total++; if (to || lat !== 2) begin bad++; $display("FAIL regr0_latency: got to=%b lat=%0d want 0/2", to, lat); end
      total++; if (rsp_rdata !== 32'hDEAD_BEEF || rsp_error !== 1'b0) begin bad++; $display("FAIL regr0_data: got d=%h e=%b want deadbeef/0", rsp_rdata, rsp_error); end
      take();
      send(1'b0, 9'h002, 32'h0, to);
      wait_rsp(lat);
      total++; if (rsp_rdata !== 32'hA5A5_0002 || rsp_error !== 1'b0) begin bad++; $display("FAIL regr2_data: got d=%h e=%b want a5a50002/0", rsp_rdata, rsp_error); end
      take();
   endtask

   task automatic test_mem;
      bit to; int lat; int r0, m0;
      r0 = reg_we_cnt; m0 = mem_we_cnt;
      send(1'b1, 9'h1FF, 32'h1234_5678, to);
      total++; if (mem_write_en !== 1'b1 || mem_address !== 8'hFF || mem_data_in !== 32'h1234_5678) begin bad++; $display("FAIL memw_strobe: got we=%b a=%h d=%h want 1/ff/12345678", mem_write_en, mem_address, mem_data_in); end
      wait_rsp(lat);
      total++; if (to || lat !== 2 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL memw_rsp: got to=%b lat=%0d d=%h want 0/2/0", to, lat, rsp_rdata); end
      take();
      total++; if (mem_we_cnt - m0 !== 1 || reg_we_cnt - r0 !== 0) begin bad++; $display("FAIL memw_pulses: got mem=%0d reg=%0d want 1/0", mem_we_cnt - m0, reg_we_cnt - r0); end
      send(1'b1, 9'h105, 32'hCAFE_F00D, to);
      wait_rsp(lat);
      take();
      send(1'b0, 9'h1FF, 32'h0, to);
      wait_rsp(lat);
      total++; if (to || lat !== 3) begin bad++; $display("FAIL memr_latency: got to=%b lat=%0d want 0/3", to, lat); end
      total++; if (rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0) begin bad++; $display("FAIL memr_data_ff: got d=%h e=%b want 12345678/0", rsp_rdata, rsp_error); end
      take();
      send(1'b0, 9'h105, 32'h0, to);
      wait_rsp(lat);
      total++; if (rsp_rdata !== 32'hCAFE_F00D || lat !== 3) begin bad++; $display("FAIL memr_data_05: got d=%h lat=%0d want cafef00d/3", rsp_rdata, lat); end
      take();
   endtask

   task automatic test_error;
      bit to; int lat; int r0, m0;
      r0 = reg_we_cnt; m0 = mem_we_cnt;
      send(1'b1, 9'h003, 32'hFFFF_FFFF, to);
      wait_rsp(lat);
      total++; if (to || lat !== 2 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL errw_rsp: got to=%b lat=%0d e=%b d=%h want 0/2/1/0", to, lat, rsp_error, rsp_rdata); end
      take();
      total++; if (reg_we_cnt - r0 !== 0 || mem_we_cnt - m0 !== 0) begin bad++; $display("FAIL errw_pulses: got reg=%0d mem=%0d want 0/0", reg_we_cnt - r0, mem_we_cnt - m0); end
      send(1'b0, 9'h0FF, 32'h0, to);
      wait_rsp(lat);
      total++; if (rsp_error !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL errr_rsp: got e=%b d=%h want 1/0", rsp_error, rsp_rdata); end
      take();
      send(1'b0, 9'h001, 32'h0, to);
      wait_rsp(lat);
      total++; if (rsp_error !== 1'b0 || rsp_rdata !== 32'h1111_1111) begin bad++; $display("FAIL err_cleared: got e=%b d=%h want 0/11111111", rsp_error, rsp_rdata); end
      take();
   endtask

   task automatic test_backpressure;
      bit to; int lat; bit stable;
      send(1'b0, 9'h002, 32'h0, to);
      wait_rsp(lat);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h000; req_wdata = 32'h77;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_0002 || rsp_error !== 1'b0 || req_ready !== 1'b0) stable = 1'b0;
      end
      total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_hold: got stable=%b want 1 (v=%b d=%h rdy=%b)", stable, rsp_valid, rsp_rdata, req_ready); end
      take();
      total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", req_ready, rsp_valid); end
      @(negedge clk);
      req_valid = 1'b0;
      total++; if (reg_write_en !== 3'b001 || reg_data_in !== 32'h77) begin bad++; $display("FAIL bp_second_accept: got en=%b d=%h want 001/00000077", reg_write_en, reg_data_in); end
      wait_rsp(lat);
      total++; if (lat !== 2 || rsp_error !== 1'b0) begin bad++; $display("FAIL bp_second_rsp: got lat=%0d e=%b want 2/0", lat, rsp_error); end
      take();
   endtask

   task automatic test_back_to_back;
      int r0;
      r0 = reg_we_cnt;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h002; req_wdata = 32'h99;
      for (int i = 0; i < 9; i++) @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      total++; if (reg_we_cnt - r0 !== 3) begin bad++; $display("FAIL b2b_throughput: got %0d writes want 3", reg_we_cnt - r0); end
      @(negedge clk);
   endtask

   task automatic test_reset_mem_wait;
      bit to; int lat; bit never;
      send(1'b0, 9'h1FF, 32'h0, to);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || reg_write_en !== 3'b000 || mem_write_en !== 1'b0 || mem_address !== 8'h0) begin bad++; $display("FAIL rst_mw_immediate: got v=%b rdy=%b reg=%b mem=%b a=%h want all 0", rsp_valid, req_ready, reg_write_en, mem_write_en, mem_address); end
      never = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) never = 1'b0;
      end
      reset = 1'b1;
      @(negedge clk);
      if (rsp_valid !== 1'b0) never = 1'b0;
      total++; if (never !== 1'b1) begin bad++; $display("FAIL rst_mw_no_rsp: got never=%b want 1", never); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mw_ready: got %b want 1", req_ready); end
      send(1'b0, 9'h1FF, 32'h0, to);
      wait_rsp(lat);
      total++; if (to || lat !== 3 || rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL rst_mw_fresh_read: got to=%b lat=%0d d=%h want 0/3/12345678", to, lat, rsp_rdata); end
      take();
   endtask

   initial begin
      test_reset();
      test_reg_write();
      test_reg_read();
      test_mem();
      test_error();
      test_backpressure();
      test_back_to_back();
      test_reset_mem_wait();
      total++; if (excl_viol !== 0) begin bad++; $display("FAIL strobe_exclusive: got %0d violations want 0", excl_viol); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
